// File: rtl/add_reduce_pkg.sv
// Shared types and constants for the add-reduce scheduler, plus a step-count
// helper that mirrors the pairwise schedule (no backpressure; pure definitions).
package add_reduce_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Number of RUN cycles needed to fold n operands down to one.
  function automatic int reduce_steps(input int n);
    int cnt;
    int k;
    int steps;
    cnt   = n;
    steps = 0;
    while (cnt > 1) begin
      k     = (cnt / 2 > 2) ? 2 : cnt / 2;
      cnt   = cnt - k;
      steps = steps + 1;
    end
    return steps;
  endfunction

endpackage

// File: rtl/add_unit.sv
// ADD_W-bit adder, carry-out dropped; combinational, zero latency, no backpressure.
module add_unit #(
  parameter int ADD_W = 13
) (
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  output logic [ADD_W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/add_reduce_sched.sv
// Sequences an N-operand modulo-2^ADD_W sum over two shared adders; done rises
// reduce_steps(N) edges after the start edge; start always wins (restart), no stall input.
module add_reduce_sched
  import add_reduce_pkg::*;
#(
  parameter int N      = 7,
  parameter int ADD_W  = 13,
  parameter int DATA_W = add_reduce_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N*DATA_W-1:0] ops,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   result,
  output logic [1:0]          add_active
);

  // Wide enough for counts up to 16 and for the constant 4 comparison at any N.
  localparam int CNT_W = 5;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADD_W-1:0] r_q [N];
  logic [ADD_W-1:0] r_d [N];
  logic [ADD_W-1:0] result_q, result_d;

  logic             issue0, issue1;
  logic [1:0]       k;
  logic [ADD_W-1:0] a0, b0, a1, b1;
  logic [ADD_W-1:0] sum0, sum1;
  logic [ADD_W-1:0] src1 [N];
  logic [ADD_W-1:0] src2 [N];
  logic             ops_unused;

  // Only the low ADD_W bits of each operand are ever captured.
  assign ops_unused = ^ops;

  assign issue0 = (state_q == RUN) && (cnt_q >= CNT_W'(2));
  assign issue1 = (state_q == RUN) && (cnt_q >= CNT_W'(4));
  assign k      = issue1 ? 2'd2 : (issue0 ? 2'd1 : 2'd0);

  assign a0 = issue0 ? r_q[0] : '0;
  assign b0 = issue0 ? r_q[1] : '0;

  generate
    if (N >= 4) begin : g_bin1_ops
      assign a1 = issue1 ? r_q[2] : '0;
      assign b1 = issue1 ? r_q[3] : '0;
    end else begin : g_bin1_idle
      assign a1 = '0;
      assign b1 = '0;
    end
  endgenerate

  add_unit #(.ADD_W(ADD_W)) bin0 (
    .a   (a0),
    .b   (b0),
    .sum (sum0)
  );

  add_unit #(.ADD_W(ADD_W)) bin1 (
    .a   (a1),
    .b   (b1),
    .sum (sum1)
  );

  // Candidate sources for the compaction: slot i pulls from slot i+k.
  generate
    for (genvar g = 0; g < N; g++) begin : g_src
      if (g + 1 < N) begin : g_s1
        assign src1[g] = r_q[g+1];
      end else begin : g_s1_z
        assign src1[g] = '0;
      end
      if (g + 2 < N) begin : g_s2
        assign src2[g] = r_q[g+2];
      end else begin : g_s2_z
        assign src2[g] = '0;
      end
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    result_d = result_q;
    if (start) begin
      for (int i = 0; i < N; i++) begin
        r_d[i] = ops[i*DATA_W +: ADD_W];
      end
      cnt_d   = CNT_W'(N);
      state_d = RUN;
    end else if (state_q == RUN) begin
      for (int i = 0; i < N; i++) begin
        if (k == 2'd2) begin
          r_d[i] = (i == 0) ? sum0 : ((i == 1) ? sum1 : src2[i]);
        end else begin
          r_d[i] = (i == 0) ? sum0 : src1[i];
        end
      end
      cnt_d = cnt_q - {{(CNT_W-2){1'b0}}, k};
      if (cnt_d == CNT_W'(1)) begin
        state_d  = DONE;
        result_d = sum0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      for (int i = 0; i < N; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      r_q      <= r_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign result     = {{(DATA_W-ADD_W){1'b0}}, result_q};
  assign add_active = {issue1, issue0};

endmodule

// File: tb/tb_add_reduce_sched.sv
// Self-checking bench for add_reduce_sched (N=7, ADD_W=13): vector table plus
// hand-written restart, reset and hold sequences; results checked via a scoreboard queue.
module tb_add_reduce_sched;

  localparam int N     = 7;
  localparam int ADD_W = 13;
  localparam int DW    = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [N*DW-1:0] ops;
  logic            busy;
  logic            done;
  logic [DW-1:0]   result;
  logic [1:0]      add_active;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];

  typedef struct {
    logic [N*DW-1:0] ops;
    logic [63:0]     exp;
  } vec_t;

  vec_t vecs [5];

  add_reduce_sched #(.N(N), .ADD_W(ADD_W), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ops        (ops),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .add_active (add_active)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] mk_ops(input logic [63:0] base, input logic [63:0] step);
    logic [N*DW-1:0] v;
    for (int j = 0; j < N; j++) begin
      v[j*DW +: DW] = base + 64'(j) * step;
    end
    return v;
  endfunction

  task automatic pop_result(input string nm);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got completion, expected none queued", nm);
    end else begin
      checks--;
      chk(nm, result, exp_q.pop_front());
    end
  endtask

  // Full run with fixed-latency cycle checks; optionally checks the held result on the restart edge.
  task automatic run_check(input string nm, input logic [N*DW-1:0] v, input logic [63:0] exp,
                           input logic hold_chk, input logic [63:0] hold_val);
    logic [1:0] pat [4];
    pat = '{2'b11, 2'b11, 2'b01, 2'b01};
    @(negedge clk);
    ops   = v;
    start = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    ops   = {(N*2){$urandom()}};
    if (hold_chk) chk({nm, "_result_held"}, result, hold_val);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("%s_add_active_c%0d", nm, c), {62'd0, add_active}, {62'd0, pat[c]});
      chk($sformatf("%s_busy_c%0d", nm, c), {63'd0, busy}, 64'd1);
      chk($sformatf("%s_done_c%0d", nm, c), {63'd0, done}, 64'd0);
      @(negedge clk);
    end
    chk({nm, "_done"}, {63'd0, done}, 64'd1);
    chk({nm, "_busy_end"}, {63'd0, busy}, 64'd0);
    chk({nm, "_add_active_end"}, {62'd0, add_active}, 64'd0);
    pop_result({nm, "_result"});
  endtask

  initial begin
    int n;
    int bad;
    logic seen;
    logic [N*DW-1:0] tv;

    vecs[0].ops = mk_ops(64'd1, 64'd1);      vecs[0].exp = 64'd28;
    vecs[1].ops = mk_ops(64'd8191, 64'd0);   vecs[1].exp = 64'd8185;
    tv = '0;
    tv[63:0] = 64'hFFFF_0000_0000_0005;
    vecs[2].ops = tv;                         vecs[2].exp = 64'd5;
    vecs[3].ops = mk_ops(64'd100, 64'd100);  vecs[3].exp = 64'd2800;
    vecs[4].ops = mk_ops(64'h0123_4567_89AB_CDEF, 64'd0); vecs[4].exp = 64'd393;

    rst_n = 1'b0;
    start = 1'b0;
    ops   = '0;
    #12;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_add_active", {62'd0, add_active}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].ops, vecs[i].exp, 1'b0, 64'd0);
    end

    // Restart after two RUN cycles: the first run must never complete.
    @(negedge clk);
    ops   = mk_ops(64'd1, 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_no_done_r0", {63'd0, done}, 64'd0);
    @(negedge clk);
    chk("restart_no_done_r1", {63'd0, done}, 64'd0);
    ops   = mk_ops(64'd2, 64'd0);
    start = 1'b1;
    exp_q.push_back(64'd14);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("restart_latency", 64'(n), 64'd4);
    pop_result("restart_result");

    // Reset during the third RUN cycle.
    @(negedge clk);
    ops   = mk_ops(64'd1, 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_result", result, 64'd0);
    chk("midrst_add_active", {62'd0, add_active}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    chk("midrst_no_activity_after_release", {63'd0, seen}, 64'd0);

    // Completion, long hold, then re-run with zero operands.
    run_check("hold_first", mk_ops(64'd1, 64'd1), 64'd28, 1'b0, 64'd0);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done !== 1'b1 || result !== 64'd28) bad++;
    end
    chk("hold_stable_cycles_bad", 64'(bad), 64'd0);
    run_check("hold_rerun", mk_ops(64'd0, 64'd0), 64'd0, 1'b1, 64'd28);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
